quad_dirdect_cnt: RTL and testbench
===================================

// Module: quad_dirdect_cnt
// PURPOSE
//  Clocked, parametrised quadrature direction detector and position counter.
//  Synchronises and glitch-filters the two encoder phases i_A/i_B, decodes the
//  Gray sequence in 1x/2x/4x resolution, keeps a wrapping position count, a
//  last-direction flag and a sticky illegal-transition flag. Sits directly
//  behind the encoder pins; outputs feed the motion/control logic.
// PARAMETERS
//  CNT_W        16  position counter width in bits (2..32)
//  SYNC_STAGES  2   synchroniser flops per phase (2..4)
//  FILT_LEN     4   consecutive equal samples needed to accept a level (1..15)
// PORTS
//  i_Clk     in   1      system clock, all logic on rising edge
//  i_Rst     in   1      synchronous active-high reset
//  i_A       in   1      encoder phase A, asynchronous
//  i_B       in   1      encoder phase B, asynchronous
//  i_Mode    in   2      00=1x, 01=2x, 10/11=4x decode resolution
//  i_Clear   in   1      synchronous count clear, 1-cycle pulse or level
//  i_ErrClr  in   1      clears o_Err
//  o_Count   out  CNT_W  position count, modulo 2^CNT_W
//  o_Forw    out  1      1-cycle pulse per counted forward step
//  o_Back    out  1      1-cycle pulse per counted backward step
//  o_UD      out  1      last counted direction, 1=forward, 0=backward
//  o_Err     out  1      sticky: illegal transition (both phases changed)
// BEHAVIOUR
//  Reset: o_Count=0, o_Forw=0, o_Back=0, o_UD=0, o_Err=0; synchronisers,
//   filter counters cleared; reference-state-valid flag cleared.
//  Sync: each phase through SYNC_STAGES flops. Filter: per phase, filtered
//   level takes the synced value once it has been equal on FILT_LEN
//   consecutive clocks; shorter pulses are discarded entirely.
//  Latency: count, pulses and o_UD update exactly SYNC_STAGES+FILT_LEN+1
//   clocks after the first clock edge sampling the new pin level.
//  Decode on state S={A_f,B_f} vs previous P, evaluated every clock:
//   forward  00->10->11->01->00 (A leads B); backward 00->01->11->10->00.
//   S==P: no event. Both bits differ: illegal -> o_Err<=1, no step, P<=S.
//  Mode gating of valid transitions:
//   4x: every valid transition is a step.
//   2x: only transitions where A changes (00<->10, 11<->01).
//   1x: only 00->10 (forward) and 10->00 (backward).
//  Step: o_Count +1 (forward) / -1 (backward), wraps max<->0 silently;
//   matching pulse high for one clock; o_UD set to step direction.
//   Ungated transitions update P only; o_UD holds.
//  First reference: after reset the first filtered state loads P and sets
//   the valid flag without step or error (any power-up phase state legal).
//  Priority: i_Rst > i_Clear > step. i_Clear forces o_Count=0 and drops a
//   coincident step (no pulse, o_UD holds); P still tracks S.
//  o_Err: set wins over i_ErrClr in the same cycle; otherwise i_ErrClr->0.
//  i_Mode may change anytime; applies to the next transition, no re-sync.
//  o_Forw and o_Back are never high together.
// TESTING
//  Reset, then 4 forward 4x cycles (16 edges, edges 20 clk apart) ->
//   o_Count=16, 16 o_Forw pulses, o_UD=1, o_Err=0.
//  Same sequence reversed in 1x mode from count 0 -> o_Count=2^CNT_W-4
//   (0xFFFC at CNT_W=16), 4 o_Back pulses, o_UD=0 (wrap-around).
//  Glitch of FILT_LEN-1 clocks on i_A while idle -> no pulse, count unchanged;
//   FILT_LEN-clock pulse -> accepted, exactly per latency formula.
//  From 00 drive A and B high on same clock -> o_Err=1, count unchanged;
//   i_ErrClr alongside a second illegal jump -> o_Err stays 1; next
//   i_ErrClr alone -> 0.
//  i_Clear asserted on the clock a forward step lands -> o_Count=0, no
//   o_Forw; following step counts to 1.
//  2x mode, 8 forward edges then i_Rst mid-sequence -> count 4 before reset,
//   all outputs 0 after; first post-reset state produces no step.

Source files
------------

// File: rtl/quad_dirdect_cnt.sv
// Quadrature direction detector and position counter.
// Synchronises and glitch-filters encoder phases A/B, decodes the Gray
// sequence in 1x/2x/4x resolution and keeps a wrapping position count,
// last-direction flag and sticky illegal-transition flag.
module quad_dirdect_cnt #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_A,
  input  logic             i_B,
  input  logic [1:0]       i_Mode,
  input  logic             i_Clear,
  input  logic             i_ErrClr,
  output logic [CNT_W-1:0] o_Count,
  output logic             o_Forw,
  output logic             o_Back,
  output logic             o_UD,
  output logic             o_Err
);

  // Settling time covers sync + filter + the cur register, so the first
  // reference is taken from a filtered state that reflects the real pins.
  localparam int WARM = SYNC_STAGES + FILT_LEN + 2;
  localparam int WW   = $clog2(WARM + 1);

  // Phase encoding {A,B}; forward order is 00 -> 10 -> 11 -> 01.
  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_10 = 2'b10,
    PH_11 = 2'b11,
    PH_01 = 2'b01
  } phase_t;

  typedef enum logic {
    ST_SETTLE,
    ST_TRACK
  } run_t;

  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic [1:0]             raw;
  logic [1:0]             filt;
  logic [1:0][3:0]        fcnt;
  phase_t                 cur;
  phase_t                 prev;
  run_t                   run;
  logic [WW-1:0]          warm;

  logic [1:0] diff;
  logic       changed;
  logic       illegal;
  logic       fwd;
  logic       gated;
  logic       err_set;
  logic       step;

  assign raw = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

  // Synchroniser chains for the asynchronous phase inputs.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], i_A};
      sync_b <= {sync_b[SYNC_STAGES-2:0], i_B};
    end
  end

  // Per-phase filter: accept a level after FILT_LEN consecutive differing samples.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      filt <= '0;
      fcnt <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (raw[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == 4'(FILT_LEN - 1)) begin
          filt[i] <= raw[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 4'd1;
        end
      end
    end
  end

  // Registered filtered state presented to the decoder.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) cur <= PH_00;
    else       cur <= phase_t'(filt);
  end

  // Transition classification and resolution gating.
  always_comb begin
    diff    = cur ^ prev;
    changed = (diff != 2'b00);
    illegal = (diff == 2'b11);
    fwd     = ((prev == PH_00) && (cur == PH_10)) ||
              ((prev == PH_10) && (cur == PH_11)) ||
              ((prev == PH_11) && (cur == PH_01)) ||
              ((prev == PH_01) && (cur == PH_00));
    gated   = 1'b0;
    case (i_Mode)
      2'b00:   gated = ((prev == PH_00) && (cur == PH_10)) ||
                       ((prev == PH_10) && (cur == PH_00));
      2'b01:   gated = diff[1];
      default: gated = 1'b1;
    endcase
    err_set = (run == ST_TRACK) && changed && illegal;
    step    = (run == ST_TRACK) && changed && !illegal && gated;
  end

  // Reference tracking FSM with registered count, pulses, direction and error.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      run     <= ST_SETTLE;
      warm    <= '0;
      prev    <= PH_00;
      o_Count <= '0;
      o_Forw  <= 1'b0;
      o_Back  <= 1'b0;
      o_UD    <= 1'b0;
      o_Err   <= 1'b0;
    end else begin
      o_Forw <= 1'b0;
      o_Back <= 1'b0;
      prev   <= cur;
      case (run)
        ST_SETTLE: begin
          if (warm == WW'(WARM - 1)) run <= ST_TRACK;
          else                       warm <= warm + WW'(1);
        end
        default: run <= ST_TRACK;
      endcase
      if (i_Clear) begin
        o_Count <= '0;
      end else if (step) begin
        if (fwd) begin
          o_Count <= o_Count + CNT_W'(1);
          o_Forw  <= 1'b1;
          o_UD    <= 1'b1;
        end else begin
          o_Count <= o_Count - CNT_W'(1);
          o_Back  <= 1'b1;
          o_UD    <= 1'b0;
        end
      end
      o_Err <= err_set | (o_Err & ~i_ErrClr);
    end
  end

endmodule

// File: tb/tb_quad_dirdect_cnt.sv
// Testbench for quad_dirdect_cnt: vector table, directed corner sequences
// and randomized pin activity checked against a behavioural model.
module tb_quad_dirdect_cnt;

  localparam int S = 2;
  localparam int F = 4;
  localparam int L = S + F + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a = 1'b0, b = 1'b0;
  logic [1:0]  mode = 2'b10;
  logic        clr = 1'b0, errclr = 1'b0;
  logic [15:0] count;
  logic        forw, back, ud, err;

  int checks = 0;
  int failures = 0;
  int nf = 0, nb = 0;
  bit started = 0;

  // model state
  bit          ha [S+F];
  bit          hb [S+F];
  logic [1:0]  q1, q2, mp, nfilt, d;
  int          mwarm;
  bit          mvalid;
  logic [15:0] ecnt;
  bit          efw, ebk, eud, eerr;

  quad_dirdect_cnt #(.CNT_W(16), .SYNC_STAGES(S), .FILT_LEN(F)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_A(a), .i_B(b), .i_Mode(mode),
    .i_Clear(clr), .i_ErrClr(errclr), .o_Count(count), .o_Forw(forw),
    .o_Back(back), .o_UD(ud), .o_Err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pos(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Behavioural model: a level is accepted when the last F samples seen
  // through the S-deep synchroniser agree; decoding works on Gray position
  // differences of the filtered state.
  initial begin
    int delta, pn, pp;
    bit counted, dirf, errset, alla, allb;
    forever begin
      @(posedge clk);
      started = 1;
      if (rst) begin
        for (int i = 0; i < S + F; i++) begin ha[i] = 0; hb[i] = 0; end
        q1 = 0; q2 = 0; mp = 0; mwarm = 0; mvalid = 0;
        ecnt = 0; efw = 0; ebk = 0; eud = 0; eerr = 0;
      end else begin
        for (int i = S + F - 1; i > 0; i--) begin ha[i] = ha[i-1]; hb[i] = hb[i-1]; end
        ha[0] = a; hb[0] = b;
        nfilt = q1;
        alla = 1; allb = 1;
        for (int j = S; j < S + F; j++) begin
          if (ha[j] != ha[S]) alla = 0;
          if (hb[j] != hb[S]) allb = 0;
        end
        if (alla) nfilt[1] = ha[S];
        if (allb) nfilt[0] = hb[S];
        d = q2; q2 = q1; q1 = nfilt;
        efw = 0; ebk = 0; errset = 0;
        if (!mvalid) begin
          mp = d;
          mwarm++;
          if (mwarm == S + F + 2) mvalid = 1;
        end else if (d != mp) begin
          pn = pos(d); pp = pos(mp);
          delta = (pn - pp + 4) % 4;
          if (delta == 2) errset = 1;
          else begin
            dirf = (delta == 1);
            if (mode[1]) counted = 1;
            else if (mode == 2'b01) counted = (d[1] != mp[1]);
            else counted = (pp == 0 && pn == 1) || (pp == 1 && pn == 0);
            if (counted && !clr) begin
              ecnt = dirf ? ecnt + 16'd1 : ecnt - 16'd1;
              efw = dirf; ebk = !dirf; eud = dirf;
            end
          end
          mp = d;
        end
        if (clr) ecnt = 0;
        eerr = errset ? 1'b1 : (errclr ? 1'b0 : eerr);
      end
    end
  end

  // Continuous comparison against the model plus pulse counting.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check("m_count", 32'(count), 32'(ecnt));
        check("m_forw", 32'(forw), 32'(efw));
        check("m_back", 32'(back), 32'(ebk));
        check("m_ud", 32'(ud), 32'(eud));
        check("m_err", 32'(err), 32'(eerr));
        check("excl", 32'(forw & back), 32'd0);
        if (forw) nf++;
        if (back) nb++;
      end
    end
  end

  typedef struct {
    bit          pa, pb;
    logic [1:0]  md;
    bit          cl, ec;
    int          hold;
    logic [15:0] cnt;
    bit          xud, xerr;
  } vec_t;

  vec_t tv [33];

  initial begin
    logic [1:0] fseq [4];
    logic [1:0] bseq [4];
    logic [1:0] ph   [4];
    logic [1:0] pins;
    int nf0, nb0, steps, p, r;
    fseq = '{2'b10, 2'b11, 2'b01, 2'b00};
    bseq = '{2'b01, 2'b11, 2'b10, 2'b00};
    ph   = '{2'b00, 2'b10, 2'b11, 2'b01};
    for (int i = 0; i < 16; i++) begin
      pins = fseq[i % 4];
      tv[i] = '{pins[1], pins[0], 2'b10, 0, 0, 20, 16'(i + 1), 1, 0};
    end
    tv[16] = '{0, 0, 2'b10, 1, 0, 1, 16'd0, 1, 0};
    for (int j = 0; j < 16; j++) begin
      pins = bseq[j % 4];
      steps = (j + 1) / 4;
      tv[17 + j] = '{pins[1], pins[0], 2'b00, 0, 0, 20, 16'(0 - steps), (steps == 0), 0};
    end

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_forw", 32'(forw), 32'd0);
    check("rst_back", 32'(back), 32'd0);
    check("rst_ud", 32'(ud), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // vector table: 4x forward, clear, 1x backward with wrap
    nf0 = nf; nb0 = nb;
    for (int r2 = 0; r2 < 33; r2++) begin
      a = tv[r2].pa; b = tv[r2].pb; mode = tv[r2].md;
      clr = tv[r2].cl; errclr = tv[r2].ec;
      repeat (tv[r2].hold) @(posedge clk);
      @(negedge clk);
      check("tv_count", 32'(count), 32'(tv[r2].cnt));
      check("tv_ud", 32'(ud), 32'(tv[r2].xud));
      check("tv_err", 32'(err), 32'(tv[r2].xerr));
      if (r2 == 15) check("fwd_pulses", 32'(nf - nf0), 32'd16);
      if (r2 == 32) check("back_pulses", 32'(nb - nb0), 32'd4);
    end
    clr = 0; errclr = 0;

    // glitch of F-1 clocks rejected
    mode = 2'b10;
    @(posedge clk); #1;
    nf0 = nf; nb0 = nb;
    a = 1;
    repeat (F - 1) @(posedge clk);
    #1 a = 0;
    repeat (20) @(negedge clk);
    check("glitch_pulses", 32'(nf - nf0 + nb - nb0), 32'd0);
    check("glitch_count", 32'(count), 32'hFFFC);

    // F-clock pulse accepted at exactly L clocks
    @(posedge clk); #1;
    a = 1;
    for (int e = 0; e <= L; e++) begin
      @(posedge clk);
      if (e == F - 1) #1 a = 0;
      @(negedge clk);
      if (e == L - 1) check("lat_early", 32'(forw), 32'd0);
      if (e == L)     check("lat_hit", 32'(forw), 32'd1);
    end
    repeat (20) @(negedge clk);
    check("pulse_count", 32'(count), 32'hFFFC);
    check("pulse_ud", 32'(ud), 32'd0);

    // illegal jump, then errclr coincident with a second illegal jump
    @(posedge clk); #1;
    a = 1; b = 1;
    repeat (20) @(negedge clk);
    check("ill_err", 32'(err), 32'd1);
    check("ill_count", 32'(count), 32'hFFFC);
    @(posedge clk); #1;
    a = 0; b = 0;
    for (int e = 0; e <= L; e++) begin
      @(posedge clk);
      if (e == L - 1) #1 errclr = 1;
      if (e == L)     #1 errclr = 0;
    end
    @(negedge clk);
    check("ill2_err_held", 32'(err), 32'd1);
    @(posedge clk); #1 errclr = 1;
    @(posedge clk); #1 errclr = 0;
    @(negedge clk);
    check("errclr_alone", 32'(err), 32'd0);
    repeat (10) @(negedge clk);

    // clear coincident with a landing forward step
    @(posedge clk); #1;
    nf0 = nf;
    a = 1;
    for (int e = 0; e <= L; e++) begin
      @(posedge clk);
      if (e == L - 1) #1 clr = 1;
      if (e == L)     #1 clr = 0;
    end
    @(negedge clk);
    check("clr_count", 32'(count), 32'd0);
    check("clr_nopulse", 32'(nf - nf0), 32'd0);
    check("clr_ud_hold", 32'(ud), 32'd0);
    b = 1;
    repeat (20) @(negedge clk);
    check("after_clr_count", 32'(count), 32'd1);
    check("after_clr_ud", 32'(ud), 32'd1);

    // 2x mode, 8 forward edges from 11, then reset mid-sequence
    clr = 1; @(negedge clk); clr = 0;
    mode = 2'b01;
    nf0 = nf;
    for (int k = 0; k < 8; k++) begin
      pins = fseq[(k + 2) % 4];
      a = pins[1]; b = pins[0];
      repeat (20) @(negedge clk);
    end
    check("x2_count", 32'(count), 32'd4);
    check("x2_pulses", 32'(nf - nf0), 32'd4);
    a = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_pulse", 32'(forw | back), 32'd0);
    check("midrst_ud", 32'(ud), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    rst = 0;
    nf0 = nf; nb0 = nb;
    repeat (30) @(negedge clk);
    check("first_ref_count", 32'(count), 32'd0);
    check("first_ref_pulses", 32'(nf - nf0 + nb - nb0), 32'd0);
    check("first_ref_err", 32'(err), 32'd0);
    mode = 2'b10;
    b = 0;
    repeat (20) @(negedge clk);
    check("post_rst_step", 32'(count), 32'd1);
    check("post_rst_ud", 32'(ud), 32'd1);

    // randomized pin activity against the model
    p = 0;
    a = 0; b = 0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 6)       p = (p + 1) % 4;
      else if (r < 12) p = (p + 3) % 4;
      else if (r < 13) p = (p + 2) % 4;
      pins = ph[p];
      a = pins[1]; b = pins[0];
      if ($urandom_range(0, 99) < 2) mode = 2'($urandom_range(0, 3));
      clr    = ($urandom_range(0, 49) == 0);
      errclr = ($urandom_range(0, 19) == 0);
      rst    = (i >= 1500 && i < 1502);
      @(negedge clk);
    end
    rst = 0; clr = 0; errclr = 0;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
